// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the CPU memory stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if;
  logic        w_req_valid;
  logic        w_req_ready;
  logic        w_req_write;
  logic [2:0]  w_req_funct3;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        w_resp_valid;
  logic        w_resp_ready;
  logic [31:0] w_resp_rdata;
  logic        w_resp_fault;

  modport master (
    output w_req_valid, w_req_write, w_req_funct3, w_req_addr, w_req_wdata, w_resp_ready,
    input  w_req_ready, w_resp_valid, w_resp_rdata, w_resp_fault
  );

  modport slave (
    input  w_req_valid, w_req_write, w_req_funct3, w_req_addr, w_req_wdata, w_resp_ready,
    output w_req_ready, w_resp_valid, w_resp_rdata, w_resp_fault
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller with RISC-V sub-word access and fault reporting.
// Optional macro DMEM_MISALIGN_FAULT_EN: misaligned half/word accesses fault instead of being force-aligned.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic        w_clk,
  input  logic        w_rst,
  dmem_ctrl_if.slave  bus
);
  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r, state_next_s;
  logic [3:0]  cnt_r;
  logic        write_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r, wdata_r;
  logic        req_ready_r, resp_valid_r, resp_fault_r;
  logic [31:0] resp_rdata_r;
  logic [31:0] mem_r [DEPTH_WORDS] = '{default: 32'h0000_0000};

  logic [IDX_W-1:0] idx_s;
  logic [1:0]  ofs_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_sh_s, word_s, word_sh_s, load_s;
  logic        range_fault_s, align_fault_s, funct3_fault_s, fault_s;
  logic        accept_s, commit_s, mem_we_s;

  assign bus.w_req_ready  = req_ready_r;
  assign bus.w_resp_valid = resp_valid_r;
  assign bus.w_resp_rdata = resp_rdata_r;
  assign bus.w_resp_fault = resp_fault_r;

  // Decode the latched request: index, lane offset, faults, store lanes and load extension.
  always_comb begin
    idx_s          = addr_r[IDX_W+1:2];
    range_fault_s  = (32'(idx_s) >= 32'(DEPTH_WORDS)) || (addr_r[31:IDX_W+2] != '0);
    funct3_fault_s = (funct3_r == 3'b011) || (funct3_r == 3'b110) || (funct3_r == 3'b111);
    case (funct3_r[1:0])
      2'b00:   ofs_s = addr_r[1:0];
      2'b01:   ofs_s = {addr_r[1], 1'b0};
      default: ofs_s = 2'b00;
    endcase
`ifdef DMEM_MISALIGN_FAULT_EN
    align_fault_s = ((funct3_r[1:0] == 2'b01) && addr_r[0]) ||
                    ((funct3_r[1:0] == 2'b10) && (addr_r[1:0] != 2'b00));
`else
    align_fault_s = 1'b0;
`endif
    fault_s = range_fault_s || align_fault_s || funct3_fault_s;
    case (funct3_r[1:0])
      2'b00:   be_s = 4'b0001 << ofs_s;
      2'b01:   be_s = 4'b0011 << ofs_s;
      2'b10:   be_s = 4'b1111;
      default: be_s = 4'b0000;
    endcase
    wdata_sh_s = wdata_r << {ofs_s, 3'b000};
    word_s     = mem_r[idx_s];
    word_sh_s  = word_s >> {ofs_s, 3'b000};
    case (funct3_r)
      3'b000:  load_s = {{24{word_sh_s[7]}}, word_sh_s[7:0]};
      3'b001:  load_s = {{16{word_sh_s[15]}}, word_sh_s[15:0]};
      3'b010:  load_s = word_s;
      3'b100:  load_s = {24'h00_0000, word_sh_s[7:0]};
      3'b101:  load_s = {16'h0000, word_sh_s[15:0]};
      default: load_s = 32'h0000_0000;
    endcase
    accept_s = bus.w_req_valid && req_ready_r && (state_r == IDLE);
    commit_s = (state_r == WAIT) && (cnt_r == 4'd0);
    mem_we_s = commit_s && write_r && !fault_s;
  end

  // Next-state logic for the IDLE -> WAIT -> RESP sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = WAIT; else state_next_s = IDLE;
      WAIT:    if (commit_s) state_next_s = RESP; else state_next_s = WAIT;
      RESP:    if (resp_valid_r && bus.w_resp_ready) state_next_s = IDLE; else state_next_s = RESP;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Request latch, latency counter and registered response outputs.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_r        <= 4'd0;
      write_r      <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_fault_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      req_ready_r <= (state_next_s == IDLE);
      if (accept_s) begin
        cnt_r    <= LAT_C;
        write_r  <= bus.w_req_write;
        funct3_r <= bus.w_req_funct3;
        addr_r   <= bus.w_req_addr;
        wdata_r  <= bus.w_req_wdata;
      end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (commit_s) begin
        resp_valid_r <= 1'b1;
        resp_fault_r <= fault_s;
        resp_rdata_r <= (!write_r && !fault_s) ? load_s : 32'h0000_0000;
      end else if ((state_r == RESP) && bus.w_resp_ready) begin
        resp_valid_r <= 1'b0;
        resp_fault_r <= 1'b0;
        resp_rdata_r <= 32'h0000_0000;
      end
    end
  end

  // Byte-lane write of a committed, non-faulting store; the array itself is never reset.
  always_ff @(posedge w_clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) mem_r[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
      end
    end
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, multi-cycle data-memory controller; successor to the single-cycle word-only data memory.
- Sits between the CPU memory stage and a word-organised storage array.
- Adds a valid/ready request handshake, a response handshake, configurable access latency, RISC-V sub-word loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane merging, and fault reporting.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; index = w_req_addr[IDX_W+1:2], IDX_W = $clog2(DEPTH_WORDS)
LATENCY, 1, extra wait cycles between accept and response (legal 0..15)

Ports:
w_clk  input  1  clock, rising edge
w_rst  input  1  asynchronous, active-high reset
w_req_valid  input  1  request present
w_req_ready  output  1  controller can accept a request
w_req_write  input  1  1 = store, 0 = load
w_req_funct3  input  3  RISC-V funct3 (size/sign)
w_req_addr  input  32  byte address
w_req_wdata  input  32  store data, right-aligned
w_resp_valid  output  1  response present
w_resp_ready  input  1  consumer takes response
w_resp_rdata  output  32  load result, extended; 0 for stores/faults
w_resp_fault  output  1  request faulted (misaligned or out of range)

Behaviour:
- Clock/reset: one clock w_clk; w_rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; w_req_ready = 1; w_resp_valid = 0; w_resp_rdata = 0; w_resp_fault = 0; wait counter = 0.
  - Array contents are not reset; they are zero-initialised at elaboration.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - w_req_ready = 1.
  - On w_req_valid & w_req_ready at edge N, latch write, funct3, addr and wdata.
  - Go to WAIT with counter = LATENCY.
- WAIT:
  - w_req_ready = 0.
  - While counter != 0, decrement each edge.
  - At the edge where counter == 0, commit the access and go to RESP.
  - With LATENCY = 0, w_resp_valid is high after edge N+1; in general, after edge N+1+LATENCY.
- Commit:
  - Store: write enabled lanes. SB lane = addr[1:0]; SH lanes {addr[1],0} and {addr[1],1}; SW all four lanes.
  - Load: read the word, select the byte/half, sign-extend (funct3 000/001) or zero-extend (100/101); funct3 010 returns the whole word.
  - Load result is registered into w_resp_rdata.
  - Unused funct3 (011, 110, 111) sets fault.
- Fault conditions:
  - Index >= DEPTH_WORDS, or address bits above the index range are nonzero.
  - Misaligned access (see Optional Feature).
  - Unused funct3.
  - On fault: no array write; w_resp_rdata = 0; w_resp_fault = 1.
- RESP:
  - w_resp_valid = 1; rdata and fault are held stable until w_resp_valid & w_resp_ready.
  - On that edge go to IDLE; w_resp_valid, w_resp_fault and w_resp_rdata return to 0.
  - No new request is accepted in the same cycle; w_req_ready stays 0 in RESP.
- Ordering:
  - One outstanding request.
  - A load issued after a store's response sees the stored data.
- Reset mid-operation:
  - Async reset in WAIT drops the request; a store not yet committed writes nothing.
  - Reset in RESP discards the response.
- Request inputs are ignored when w_req_ready = 0.

Optional Feature:
- Macro: DMEM_MISALIGN_FAULT_EN.
- Defined: halfword with addr[0] = 1, or word with addr[1:0] != 0, sets w_resp_fault; no write; rdata = 0.
- Undefined: misaligned requests never fault on alignment; low address bits are forced to natural alignment (half: addr[0] = 0; word: addr[1:0] = 0) and the access proceeds normally.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, fault 0; response one cycle after LATENCY wait cycles.
- Array word 0x10 = 0xDEADBEEF:
  - SB 0x13 data 0x000000A5; LW 0x10 -> 0xA5ADBEEF.
  - LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
  - LH 0x12 -> 0xFFFFA5AD; LHU 0x12 -> 0x0000A5AD.
- LATENCY = 3: accept at edge N -> resp_valid rises after edge N+4; w_resp_ready held 0 for 5 cycles -> rdata/valid stable, w_req_ready = 0 throughout.
- SW addr 0x100 (DEPTH_WORDS = 64) -> fault 1, rdata 0, subsequent LW 0x0 unaffected (0).
- LW addr 0x12:
  - With DMEM_MISALIGN_FAULT_EN -> fault 1.
  - Without -> returns word at 0x10, fault 0.
- Start SW 0x20 data 0x12345678 with LATENCY = 4, assert w_rst during WAIT -> resp_valid 0, w_req_ready 1, and LW 0x20 afterwards -> 0x00000000.
